// File: rtl/synth_pkg.sv
// Shared constants, FSM state type, synthesis gain table and the output
// round/saturate helper for the subband synthesizer.
package synth_pkg;

    localparam int NBANDS = 16;
    localparam int IN_W   = 27;
    localparam int GAIN_W = 10;
    localparam int OUT_W  = 10;
    localparam int SHIFT  = 8;
    localparam int ACC_W  = IN_W + GAIN_W + 4;
    localparam int IDX_W  = $clog2(NBANDS);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBANDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_ROUND = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    typedef logic signed [GAIN_W-1:0] gain_t;

    // Unity gain at SHIFT=8; production tables are substituted here only.
    localparam gain_t GAIN [NBANDS] = '{default: 10'sd256};

    localparam logic signed [ACC_W-1:0] RND_BIAS = {{(ACC_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'((32'sd1 <<< (OUT_W - 1)) - 32'sd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN  = ACC_W'(-(32'sd1 <<< (OUT_W - 1)));

    typedef struct packed {
        logic signed [OUT_W-1:0] data;
        logic                    clamped;
    } sat_t;

    function automatic sat_t sat_round(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] rnd;
        sat_t res;
        rnd = (acc + RND_BIAS) >>> SHIFT;
        if (rnd > OUT_MAX) begin
            res.data    = OUT_MAX[OUT_W-1:0];
            res.clamped = 1'b1;
        end else if (rnd < OUT_MIN) begin
            res.data    = OUT_MIN[OUT_W-1:0];
            res.clamped = 1'b1;
        end else begin
            res.data    = rnd[OUT_W-1:0];
            res.clamped = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/subband_synthesizer_if.sv
// Frame input / sample output handshake bundle of the subband synthesizer.
interface subband_synthesizer_if;
    import synth_pkg::*;

    logic signed [IN_W-1:0]  band_in [NBANDS];
    logic                    band_valid;
    logic                    band_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sat_flag;

    modport master (
        output band_in, band_valid, out_ready,
        input  band_ready, out_data, out_valid, sat_flag
    );

    modport slave (
        input  band_in, band_valid, out_ready,
        output band_ready, out_data, out_valid, sat_flag
    );

endinterface

// File: rtl/synth_mac.sv
// Signed multiply-accumulate; the accumulator is wide enough that a full
// frame of extreme products cannot wrap.
module synth_mac
    import synth_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     enable,
    input  logic signed [IN_W-1:0]   sample,
    input  logic signed [GAIN_W-1:0] gain,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [IN_W+GAIN_W-1:0] prod_s;
    logic signed [ACC_W-1:0]       prod_ext_s;

    assign prod_s     = sample * gain;
    assign prod_ext_s = {{(ACC_W-IN_W-GAIN_W){prod_s[IN_W+GAIN_W-1]}}, prod_s};

    // Accumulator register: clear at frame start, add one product per step.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + prod_ext_s;
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/subband_synthesizer.sv
// Subband synthesizer: captures a frame of NBANDS samples, forms the gain
// weighted sum over NBANDS steps, rounds/saturates and holds the result.
module subband_synthesizer
    import synth_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clk_enable,
    subband_synthesizer_if.slave bus
);

    state_t                  state_r, next_state_s;
    logic [IDX_W-1:0]        idx_r;
    logic signed [IN_W-1:0]  bank_r [NBANDS];
    logic signed [ACC_W-1:0] acc_s;
    logic signed [OUT_W-1:0] out_data_r;
    logic                    out_valid_r, sat_flag_r, band_ready_r;
    logic                    capture_s, mac_en_s, load_s, release_s;
    sat_t                    sat_s;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; disabled edges leave the state unchanged.
    always_comb begin
        next_state_s = state_r;
        if (clk_enable) begin
            case (state_r)
                ST_IDLE:  next_state_s = bus.band_valid ? ST_ACCUM : ST_IDLE;
                ST_ACCUM: next_state_s = (idx_r == IDX_LAST) ? ST_ROUND : ST_ACCUM;
                ST_ROUND: next_state_s = ST_HOLD;
                ST_HOLD:  next_state_s = bus.out_ready ? ST_IDLE : ST_HOLD;
                default:  next_state_s = ST_IDLE;
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // Per-state datapath strobes, qualified by the global enable.
    always_comb begin
        capture_s = 1'b0;
        mac_en_s  = 1'b0;
        load_s    = 1'b0;
        release_s = 1'b0;
        if (clk_enable) begin
            case (state_r)
                ST_IDLE:  capture_s = bus.band_valid;
                ST_ACCUM: mac_en_s  = 1'b1;
                ST_ROUND: load_s    = 1'b1;
                ST_HOLD:  release_s = bus.out_ready;
                default:  capture_s = 1'b0;
            endcase
        end else begin
            capture_s = 1'b0;
        end
    end

    // Sample bank and step index; the bank is frozen once a frame is taken.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_r <= '0;
            for (int i = 0; i < NBANDS; i++) bank_r[i] <= '0;
        end else if (capture_s) begin
            idx_r <= '0;
            for (int i = 0; i < NBANDS; i++) bank_r[i] <= bus.band_in[i];
        end else if (mac_en_s) begin
            idx_r <= idx_r + IDX_ONE;
        end else begin
            idx_r <= idx_r;
        end
    end

    synth_mac u_mac (
        .clock  (clock),
        .reset  (reset),
        .clear  (capture_s),
        .enable (mac_en_s),
        .sample (bank_r[idx_r]),
        .gain   (GAIN[idx_r]),
        .acc    (acc_s)
    );

    assign sat_s = sat_round(acc_s);

    // Output sample, valid, sticky saturation flag and registered ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_data_r   <= '0;
            out_valid_r  <= 1'b0;
            sat_flag_r   <= 1'b0;
            band_ready_r <= 1'b1;
        end else begin
            band_ready_r <= (next_state_s == ST_IDLE);
            if (load_s) begin
                out_data_r  <= sat_s.data;
                out_valid_r <= 1'b1;
                sat_flag_r  <= sat_flag_r | sat_s.clamped;
            end else if (release_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign bus.out_data   = out_data_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.sat_flag   = sat_flag_r;
    assign bus.band_ready = band_ready_r;

endmodule

// File: tb/tb_subband_synthesizer.sv
// Directed self-checking bench for subband_synthesizer (unity gain table).
module tb_subband_synthesizer;
    import synth_pkg::*;

    logic clock;
    logic reset;
    logic clk_enable;
    int   total = 0;
    int   bad   = 0;

    subband_synthesizer_if bus ();

    subband_synthesizer dut (
        .clock      (clock),
        .reset      (reset),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic fill(input int base, input int inc);
        for (int i = 0; i < NBANDS; i++) bus.band_in[i] = 27'(base + inc * i);
    endtask

    // Offer a frame, measure latency to out_valid, check data, then release.
    task automatic do_frame(input string tag, input int exp_data, input bit scramble);
        int cnt;
        bus.band_valid = 1'b1;
        step(1);
        bus.band_valid = 1'b0;
        if (scramble) fill(99, 7);
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 40) begin
            step(1);
            cnt++;
        end
        chk({tag, "_lat"}, cnt, 17);
        chk({tag, "_data"}, bus.out_data, exp_data);
        bus.out_ready = 1'b1;
        step(1);
        chk({tag, "_rel_valid"}, {31'd0, bus.out_valid}, 0);
        chk({tag, "_rel_ready"}, {31'd0, bus.band_ready}, 1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clk_enable = 1'b1;
        bus.band_valid = 1'b0;
        bus.out_ready = 1'b0;
        fill(0, 0);
        step(3);
        chk("rst_data", bus.out_data, 0);
        chk("rst_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_sat", {31'd0, bus.sat_flag}, 0);
        chk("rst_ready", {31'd0, bus.band_ready}, 1);
        reset = 1'b1;

        // Unity gain, all ones; band_in scrambled after acceptance.
        fill(1, 0);
        do_frame("ones", 16, 1'b1);
        chk("ones_sat", {31'd0, bus.sat_flag}, 0);

        fill(-2, 0);
        do_frame("neg2", -32, 1'b0);
        chk("neg2_sat", {31'd0, bus.sat_flag}, 0);

        fill(0, 16);
        do_frame("ramp", 511, 1'b0);
        chk("ramp_sat", {31'd0, bus.sat_flag}, 1);

        // out_ready held high outside HOLD must not disturb the frame.
        fill(0, 0);
        bus.out_ready = 1'b1;
        do_frame("zero", 0, 1'b0);
        chk("zero_sat", {31'd0, bus.sat_flag}, 1);

        // Long HOLD with back-pressure and ignored band_valid pulses.
        fill(1, 0);
        bus.band_valid = 1'b1;
        step(1);
        bus.band_valid = 1'b0;
        step(17);
        chk("hold_entry", {31'd0, bus.out_valid}, 1);
        for (int k = 0; k < 10; k++) begin
            bus.band_valid = k[0];
            fill(k + 5, 3);
            step(1);
            chk("hold_data", bus.out_data, 16);
            chk("hold_ready", {31'd0, bus.band_ready}, 0);
        end
        bus.band_valid = 1'b0;
        clk_enable = 1'b0;
        bus.out_ready = 1'b1;
        step(1);
        chk("hold_dis_valid", {31'd0, bus.out_valid}, 1);
        clk_enable = 1'b1;
        step(1);
        chk("hold_rel_valid", {31'd0, bus.out_valid}, 0);
        chk("hold_rel_ready", {31'd0, bus.band_ready}, 1);
        bus.out_ready = 1'b0;

        // Enable toggling every other edge: valid rises on edge 34.
        fill(1, 0);
        bus.band_valid = 1'b1;
        step(1);
        bus.band_valid = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            clk_enable = (k % 2 == 0);
            step(1);
        end
        chk("tog_early", {31'd0, bus.out_valid}, 0);
        clk_enable = 1'b1;
        step(1);
        chk("tog_valid", {31'd0, bus.out_valid}, 1);
        chk("tog_data", bus.out_data, 16);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;

        // Reset asserted mid-accumulation clears outputs at once.
        fill(1, 0);
        bus.band_valid = 1'b1;
        step(1);
        bus.band_valid = 1'b0;
        step(7);
        #2 reset = 1'b0;
        #1;
        chk("mrst_data", bus.out_data, 0);
        chk("mrst_valid", {31'd0, bus.out_valid}, 0);
        chk("mrst_sat", {31'd0, bus.sat_flag}, 0);
        chk("mrst_ready", {31'd0, bus.band_ready}, 1);
        step(2);
        reset = 1'b1;
        step(20);
        chk("mrst_stale", {31'd0, bus.out_valid}, 0);
        do_frame("post_rst", 16, 1'b0);
        chk("post_rst_sat", {31'd0, bus.sat_flag}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/subband_synthesizer.md
SUBBAND_SYNTHESIZER -- requirements
Module: subband_synthesizer

Interface
REQ-001 Parameter NBANDS, 16, number of subband channels combined per output sample.
REQ-002 Parameter IN_W, 27, signed width of each subband sample.
REQ-003 Parameter GAIN_W, 10, signed width of each per-band synthesis gain.
REQ-004 Parameter OUT_W, 10, signed width of the reconstructed output sample.
REQ-005 Parameter SHIFT, 8, right-shift applied to the accumulator before saturation.
REQ-006 clock  in  1  single rising-edge clock; the block has no other clock.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 clk_enable  in  1  global enable; when low, all state freezes.
REQ-009 band_in  in  IN_W x NBANDS  unpacked array of subband samples from the analysis filterbank.
REQ-010 band_valid  in  1  band_in holds a complete frame.
REQ-011 band_ready  out  1  block can accept a frame.
REQ-012 out_data  out  OUT_W  reconstructed sample, signed.
REQ-013 out_valid  out  1  out_data is valid.
REQ-014 out_ready  in  1  downstream accepts out_data.
REQ-015 sat_flag  out  1  sticky flag; set when any output saturates.

Function
REQ-016 The FSM SHALL have the states IDLE, ACCUM, ROUND and HOLD, and every transition SHALL occur only on an edge with clk_enable=1.
REQ-017 In IDLE, band_ready SHALL be 1; in every other state it SHALL be 0.
REQ-018 In IDLE, band_valid=1 SHALL capture all NBANDS samples into a local bank, clear the accumulator, set index=0, and move the FSM to ACCUM.
REQ-019 In ACCUM, each enabled edge SHALL add band[index]*GAIN[index] to the accumulator and increment index; on the edge with index=NBANDS-1 the FSM SHALL move to ROUND.
REQ-020 The accumulator SHALL be IN_W+GAIN_W+4 bits (41) wide and SHALL never wrap.
REQ-021 In ROUND, out_data SHALL load sat((acc + 2^(SHIFT-1)) >>> SHIFT), clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_valid SHALL be set and the FSM SHALL move to HOLD.
REQ-022 Latency: out_valid SHALL rise exactly NBANDS+1 (17) enabled edges after the accepting edge.
REQ-023 In HOLD, out_data and out_valid SHALL stay stable until an enabled edge samples out_ready=1; that edge SHALL clear out_valid and return the FSM to IDLE.
REQ-024 out_ready=1 seen outside HOLD SHALL be ignored.
REQ-025 band_valid while band_ready=0 SHALL be ignored; that frame is not captured, and the upstream holds or drops it.
REQ-026 Captured bank values SHALL be unaffected by changes to band_in after the accepting edge.
REQ-027 sat_flag SHALL set on any ROUND that clamps, and SHALL clear only on reset.
REQ-028 With clk_enable=0, the FSM, index, accumulator and outputs SHALL hold their values; out_valid SHALL remain asserted if it was set.

Reset
REQ-029 reset=0 SHALL asynchronously force: FSM=IDLE, index=0, accumulator=0, bank=0, out_data=0, out_valid=0, sat_flag=0, band_ready=1.
REQ-030 Reset asserted mid-frame SHALL discard the frame; no partial output SHALL appear after release.
REQ-031 The first frame SHALL be acceptable on the first enabled edge after reset deasserts.

Structure
REQ-032 Shared package synth_pkg SHALL hold NBANDS, the width constants, the state enum, and the GAIN table (NBANDS x GAIN_W signed).
REQ-033 The package default GAIN table SHALL be all 256 (unity at SHIFT=8); production tables SHALL replace it in the package only.
REQ-034 Multiply-accumulate SHALL be a sub-module synth_mac (inputs: sample, gain, clear, enable; output: acc); the FSM, bank and saturation SHALL stay in the top level.

Verification
REQ-035 Unity gains, all bands=1 -> out_data=16 on the 17th enabled edge after acceptance; sat_flag=0.
REQ-036 All bands=-2 -> out_data=-32; then band k=16*k (sum 1920) -> out_data=511 and sat_flag=1, still 1 after the next frame with all bands=0 (out_data=0).
REQ-037 out_ready held 0 for 10 cycles in HOLD -> out_data stable and band_ready=0 throughout; band_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-038 clk_enable toggled 0/1 every other cycle during ACCUM -> same result as REQ-035, after 34 clock edges.
REQ-039 reset pulsed low at accumulate step 7 -> all outputs 0 immediately; a new all-1 frame after release yields 16 with no stale output.
